// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch-side blocks.
//   CPU_PC_W      - width of every program counter in this CPU
//   CPU_RAS_DEPTH - default number of return-address stack entries
//   CPU_RESET_PC  - address fetched first after reset
//   req_e         - the single control-flow request honoured in a cycle
package cpu_pkg;

  localparam int CPU_PC_W      = 5;
  localparam int CPU_RAS_DEPTH = 4;
  localparam logic [CPU_PC_W-1:0] CPU_RESET_PC = '0;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_BRANCH = 2'd1,
    REQ_CALL   = 2'd2,
    REQ_RET    = 2'd3
  } req_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data one slot above the current top
//   pop        - discard the current top
//   push_data  - return address to store
//   top_data   - entry at the current top (meaningless while empty)
//   empty      - no valid entries
//   ras_ovf    - sticky: a push happened while full (oldest entry lost)
//   ras_unf    - sticky: a pop happened while empty
module ras_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = CPU_RAS_DEPTH,
  parameter int W     = CPU_PC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         ras_ovf,
  output logic         ras_unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign top_data = mem_q[top_q];
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

  // A push while full advances the pointer onto the oldest slot, so the
  // overwrite falls out of the circular arithmetic; only count is held.
  // A pop while empty leaves pointer and count alone and just flags it.
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      top_d        = top_q + 1'b1;
      mem_d[top_d] = push_data;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset; an empty stack is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and drives the external PC update mux.
//   clk, rst        - clock, synchronous active-high reset
//   stall           - hold all state; no request is accepted
//   instr_pc        - PC of the decode instruction (call return address - 1)
//   is_branch/branch_taken/branch_target - conditional branch request
//   is_call/call_target                  - call request
//   is_ret                               - return request
//   pc              - current fetch PC
//   seq_pc          - pc+1, mux sequential input
//   tgt             - redirect target, mux target input
//   sel_branch, sel_con, sel_call_ret    - mux selects
//   flush           - squash the instruction fetched last cycle
//   ras_ovf/ras_unf - sticky return-stack overflow / underflow
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int RAS_DEPTH = CPU_RAS_DEPTH,
  parameter int PC_W      = CPU_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [PC_W-1:0] instr_pc,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            is_call,
  input  logic [PC_W-1:0] call_target,
  input  logic            is_ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] seq_pc,
  output logic [PC_W-1:0] tgt,
  output logic            sel_branch,
  output logic            sel_con,
  output logic            sel_call_ret,
  output logic            flush,
  output logic            ras_ovf,
  output logic            ras_unf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  req_e            req;
  logic            redirect;
  logic            ras_push, ras_pop, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign seq_pc = pc_q + 1'b1;

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(instr_pc + 1'b1),
    .top_data (ras_top),
    .empty    (ras_empty),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  // During a flush cycle decode holds a wrong-path instruction, so nothing
  // is accepted then; ret beats call beats branch when several arrive.
  always_comb begin
    req = REQ_NONE;
    if (!stall && !flush_q) begin
      if      (is_ret)    req = REQ_RET;
      else if (is_call)   req = REQ_CALL;
      else if (is_branch) req = REQ_BRANCH;
    end
  end

  // Mux selects, target and stack commands for the accepted request. A
  // return on an empty stack still redirects, to address zero.
  always_comb begin
    sel_branch   = 1'b0;
    sel_con      = 1'b0;
    sel_call_ret = 1'b0;
    tgt          = '0;
    redirect     = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    case (req)
      REQ_RET: begin
        sel_call_ret = 1'b1;
        tgt          = ras_empty ? '0 : ras_top;
        redirect     = 1'b1;
        ras_pop      = 1'b1;
      end
      REQ_CALL: begin
        sel_call_ret = 1'b1;
        tgt          = call_target;
        redirect     = 1'b1;
        ras_push     = 1'b1;
      end
      REQ_BRANCH: begin
        sel_branch = 1'b1;
        sel_con    = branch_taken;
        tgt        = branch_target;
        redirect   = branch_taken;
      end
      default: ;
    endcase
  end

  // Same value the external mux produces; redirect is already low when
  // stalled, so flush falls to zero on a stalled edge.
  always_comb begin
    pc_d    = stall ? pc_q : (redirect ? tgt : seq_pc);
    flush_d = redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_W'(CPU_RESET_PC);
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

endmodule
